// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counting timer with optional prescaler.
//
// Software or a control FSM loads a tick count, starts the timer, and may pause
// and resume it. `expired` pulses for one cycle when the count reaches zero.
// Per-cycle input priority is reset > load > stop > start > tick.
//
// Build option:
//   COUNTDOWN_AUTORELOAD_EN - when defined, a tick at count 1 reloads `count`
//                             from the reload register and keeps running. This
//                             gives periodic expiry. When undefined, the timer
//                             stops at 0 in DONE.
//
// Parameters:
//   DATA_WIDTH - width of count, load_value and the reload register
//   PRESCALE   - clk cycles per timer tick (>= 1)
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high reset
//   load       - capture load_value into count and reload registers, go IDLE
//   load_value - tick count to load
//   start      - begin or resume counting
//   stop       - pause counting
//   count      - remaining ticks (registered)
//   running    - high while in RUN
//   done       - high while in DONE
//   expired    - one-cycle pulse on reaching zero (or on reload)

module countdown_timer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  running,
    output logic                  done,
    output logic                  expired
);

    localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(PRESCALE - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StPaused = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    logic [1:0]            state_q,   state_d;
    logic [DATA_WIDTH-1:0] count_q,   count_d;
    logic [DATA_WIDTH-1:0] reload_q,  reload_d;
    logic [PrescW-1:0]     presc_q,   presc_d;
    logic                  expired_q, expired_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        presc_d   = presc_q;
        expired_d = 1'b0;

        if (load) begin
            // Abandons any in-flight run without an expiry pulse.
            count_d  = load_value;
            reload_d = load_value;
            presc_d  = '0;
            state_d  = StIdle;
        end else if (stop) begin
            // Stop wins over start. Only RUN reacts; count and presc are held.
            if (state_q == StRun) begin
                state_d = StPaused;
            end
        end else if (start && (state_q == StIdle || state_q == StPaused)) begin
            if (count_q != '0) begin
                state_d = StRun;
            end else begin
                state_d   = StDone;
                expired_d = 1'b1;
            end
        end else if (state_q == StRun) begin
            if (presc_q == PrescMax) begin
                presc_d = '0;
                if (count_q > DATA_WIDTH'(1)) begin
                    count_d = count_q - DATA_WIDTH'(1);
                end else if (count_q == DATA_WIDTH'(1)) begin
                    expired_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    count_d   = reload_q;
`else
                    count_d   = '0;
                    state_d   = StDone;
`endif
                end
            end else begin
                presc_d = presc_q + PrescW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            reload_q  <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            presc_q   <= presc_d;
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign running = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed testbench for countdown_timer. It uses two instances: PRESCALE=1 (a_*)
// and PRESCALE=4 (b_*). Inputs change and outputs are sampled 1 time unit after
// each rising edge.

module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_load, a_start, a_stop;
    logic [15:0] a_lv;
    logic [15:0] a_count;
    logic        a_running, a_done, a_expired;
    logic        b_load, b_start, b_stop;
    logic [15:0] b_lv;
    logic [15:0] b_count;
    logic        b_running, b_done, b_expired;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    countdown_timer #(.DATA_WIDTH(16), .PRESCALE(1)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .load       (a_load),
        .load_value (a_lv),
        .start      (a_start),
        .stop       (a_stop),
        .count      (a_count),
        .running    (a_running),
        .done       (a_done),
        .expired    (a_expired)
    );

    countdown_timer #(.DATA_WIDTH(16), .PRESCALE(4)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .load       (b_load),
        .load_value (b_lv),
        .start      (b_start),
        .stop       (b_stop),
        .count      (b_count),
        .running    (b_running),
        .done       (b_done),
        .expired    (b_expired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset   = 1'b1;
        a_load  = 1'b0; a_start = 1'b0; a_stop = 1'b0; a_lv = '0;
        b_load  = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_lv = '0;
        steps(2);
        reset = 1'b0;

        // Reset state
        check("rst_a_count",   a_count,   0);
        check("rst_a_running", a_running, 0);
        check("rst_a_done",    a_done,    0);
        check("rst_a_expired", a_expired, 0);
        check("rst_b_count",   b_count,   0);

`ifdef COUNTDOWN_AUTORELOAD_EN
        // Periodic reload: 3,2,1,3,2,1,...
        a_load = 1'b1; a_lv = 16'd3; step(); a_load = 1'b0;
        a_start = 1'b1; step(); a_start = 1'b0;
        check("ar_start_count", a_count, 3);
        for (int i = 1; i <= 9; i++) begin
            step();
            check("ar_count",   a_count,   3 - (i % 3));
            check("ar_expired", a_expired, (i % 3) == 0);
            check("ar_done",    a_done,    0);
            check("ar_running", a_running, 1);
        end
`else
        // PRESCALE=1: 5,4,3,2,1,0
        a_load = 1'b1; a_lv = 16'd5; step(); a_load = 1'b0;
        check("p1_load_count",   a_count,   5);
        check("p1_load_running", a_running, 0);
        a_start = 1'b1; step(); a_start = 1'b0;
        check("p1_start_running", a_running, 1);
        check("p1_start_count",   a_count,   5);
        for (int k = 4; k >= 0; k--) begin
            step();
            check("p1_count",   a_count,   k);
            check("p1_expired", a_expired, k == 0);
            check("p1_done",    a_done,    k == 0);
        end
        step();
        check("p1_expired_once", a_expired, 0);
        check("p1_done_hold",    a_done,    1);
        check("p1_count_hold",   a_count,   0);

        // PRESCALE=4: load 3, decrements after every 4th edge
        b_load = 1'b1; b_lv = 16'd3; step(); b_load = 1'b0;
        b_start = 1'b1; step(); b_start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("p4_count",   b_count,   3 - (i / 4));
            check("p4_expired", b_expired, i == 12);
            check("p4_done",    b_done,    i == 12);
        end
`endif

        // Pause/resume with PRESCALE=4: stop at count 7, presc 2
        b_load = 1'b1; b_lv = 16'd10; step(); b_load = 1'b0;
        b_start = 1'b1; step(); b_start = 1'b0;
        steps(14);
        check("pr_pre_stop_count", b_count, 7);
        b_stop = 1'b1; step(); b_stop = 1'b0;
        check("pr_paused_running", b_running, 0);
        check("pr_paused_count",   b_count,   7);
        steps(20);
        check("pr_hold_count",   b_count,   7);
        check("pr_hold_running", b_running, 0);
        b_start = 1'b1; step(); b_start = 1'b0;
        check("pr_resume_running", b_running, 1);
        check("pr_resume_count",   b_count,   7);
        step();
        check("pr_resume_1", b_count, 7);
        step();
        check("pr_resume_2", b_count, 6);

        // Priority: start+stop in RUN pauses; in PAUSED nothing changes
        b_start = 1'b1; b_stop = 1'b1; step();
        check("pri_ss_run_running", b_running, 0);
        check("pri_ss_run_count",   b_count,   6);
        check("pri_ss_run_done",    b_done,    0);
        step(); b_start = 1'b0; b_stop = 1'b0;
        check("pri_ss_paused_running", b_running, 0);
        // load + start: load wins, start dropped
        b_load = 1'b1; b_lv = 16'd9; b_start = 1'b1; step();
        b_load = 1'b0; b_start = 1'b0;
        check("pri_ls_count",   b_count,   9);
        check("pri_ls_running", b_running, 0);
        step();
        check("pri_ls_still_idle", b_running, 0);
        // start with count 0 -> DONE, single expired
        b_load = 1'b1; b_lv = 16'd0; step(); b_load = 1'b0;
        b_start = 1'b1; step(); b_start = 1'b0;
        check("pri_z_done",    b_done,    1);
        check("pri_z_expired", b_expired, 1);
        check("pri_z_count",   b_count,   0);
        check("pri_z_running", b_running, 0);
        step();
        check("pri_z_expired_once", b_expired, 0);
        check("pri_z_done_hold",    b_done,    1);
        b_start = 1'b1; step(); b_start = 1'b0;
        check("pri_z_restart_done",    b_done,    1);
        check("pri_z_restart_expired", b_expired, 0);

        // Reset mid-run
        a_load = 1'b1; a_lv = 16'd100; step(); a_load = 1'b0;
        a_start = 1'b1; step(); a_start = 1'b0;
        steps(30);
        check("rr_mid_count", a_count, 70);
        reset = 1'b1; step(); reset = 1'b0;
        check("rr_count",   a_count,   0);
        check("rr_running", a_running, 0);
        check("rr_done",    a_done,    0);
        check("rr_expired", a_expired, 0);
        step();
        check("rr_expired_after", a_expired, 0);
        a_start = 1'b1; step(); a_start = 1'b0;
        check("rr_start_done",    a_done,    1);
        check("rr_start_expired", a_expired, 1);
        check("rr_start_count",   a_count,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
